// File: rtl/serial_add_seq_if.sv
// Bundle of the operand/result handshake and the full-adder cell hookup
// for the bit-serial adder. The slave side is the adder itself; the master
// side is whoever issues operands and supplies the one-bit adder cell.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_x;
    logic             fa_y;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, fa_s, fa_cout,
        input  fa_x, fa_y, fa_cin, sum, cout, busy, done
    );

    modport slave (
        input  start, a, b, cin, fa_s, fa_cout,
        output fa_x, fa_y, fa_cin, sum, cout, busy, done
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder: streams the operands LSB first through an external
// one-bit full adder cell, one bit per clock, and collects the sum bits in
// a shift register. The visible result register is only written when the
// last bit is stored, so an aborted operation never exposes partial sums.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_seq_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic [CW-1:0]    cnt_r;
    logic             in_run_s;

    // Next-state decode; start is only honoured from IDLE or DONE.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CW'(WIDTH - 1)) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand/sum shifters, running carry, bit counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (load_s) begin
            a_sh_r   <= bus.a;
            b_sh_r   <= bus.b;
            carry_r  <= bus.cin;
            sum_sh_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (step_s) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            sum_sh_r <= {bus.fa_s, sum_sh_r[WIDTH-1:1]};
            carry_r  <= bus.fa_cout;
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                sum_r  <= {bus.fa_s, sum_sh_r[WIDTH-1:1]};
                cout_r <= bus.fa_cout;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            sum_sh_r <= sum_sh_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    // Outputs are decoded straight from registers; the adder cell sees
    // zeros whenever no bit is being processed.
    assign in_run_s   = (state_r == RUN);
    assign bus.fa_x   = in_run_s & a_sh_r[0];
    assign bus.fa_y   = in_run_s & b_sh_r[0];
    assign bus.fa_cin = in_run_s & carry_r;
    assign bus.busy   = in_run_s;
    assign bus.done   = (state_r == DONE);
    assign bus.sum    = sum_r;
    assign bus.cout   = cout_r;
endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: an 8-bit instance driven with
// directed and random operations, and a 4-bit instance swept exhaustively.
// Expected results and done timing are queued when each start is issued and
// checked by independent monitors whenever done is seen.
module tb_serial_add_seq;
    typedef struct {
        logic [32:0] res;
        int          done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   armed = 1'b0;
    bit   fin8 = 1'b0;
    bit   fin4 = 1'b0;
    exp_t q8[$];
    exp_t q4[$];

    serial_add_seq_if #(.WIDTH(8)) u8 ();
    serial_add_seq_if #(.WIDTH(4)) u4 ();

    // External one-bit full adder cells.
    assign u8.fa_s    = u8.fa_x ^ u8.fa_y ^ u8.fa_cin;
    assign u8.fa_cout = (u8.fa_x & u8.fa_y) | (u8.fa_cin & (u8.fa_x ^ u8.fa_y));
    assign u4.fa_s    = u4.fa_x ^ u4.fa_y ^ u4.fa_cin;
    assign u4.fa_cout = (u4.fa_x & u4.fa_y) | (u4.fa_cin & (u4.fa_x ^ u4.fa_y));

    serial_add_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(u8));
    serial_add_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(u4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue one 8-bit add at a negedge where the DUT is idle or in DONE;
    // returns at the negedge of the expected done cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input bit hold, input bit poke);
        exp_t e;
        u8.a = a; u8.b = b; u8.cin = c; u8.start = 1'b1;
        e.res = 33'(a) + 33'(b) + 33'(c);
        e.done_at = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        if (!hold) u8.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            u8.a = 8'($urandom); u8.b = 8'($urandom); u8.cin = 1'($urandom);
            if (!hold) u8.start = poke && (i == 3);
            @(negedge clk);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t e;
        u4.a = a; u4.b = b; u4.cin = c; u4.start = 1'b1;
        e.res = 33'(a) + 33'(b) + 33'(c);
        e.done_at = cyc + 1 + 4;
        q4.push_back(e);
        @(negedge clk);
        u4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u4.a = 4'($urandom); u4.b = 4'($urandom); u4.cin = 1'($urandom);
            @(negedge clk);
        end
    endtask

    // Monitor for the 8-bit instance.
    initial begin
        exp_t e;
        int blen = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (!u8.busy) chk("w8_fa_zero_outside_run", 33'({u8.fa_x, u8.fa_y, u8.fa_cin}), 33'(0));
                if (u8.busy) blen++;
                else if (!u8.done) blen = 0;
                if (u8.done) begin
                    if (q8.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL w8_unexpected_done: done seen with nothing pending (cycle %0d)", cyc);
                    end else begin
                        e = q8.pop_front();
                        chk("w8_result", 33'({u8.cout, u8.sum}), e.res);
                        chk("w8_done_cycle", 33'(cyc), 33'(e.done_at));
                        chk("w8_busy_len", 33'(blen), 33'(8));
                    end
                    blen = 0;
                end
            end
        end
    end

    // Monitor for the 4-bit instance.
    initial begin
        exp_t e;
        int blen = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (!u4.busy) chk("w4_fa_zero_outside_run", 33'({u4.fa_x, u4.fa_y, u4.fa_cin}), 33'(0));
                if (u4.busy) blen++;
                else if (!u4.done) blen = 0;
                if (u4.done) begin
                    if (q4.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL w4_unexpected_done: done seen with nothing pending (cycle %0d)", cyc);
                    end else begin
                        e = q4.pop_front();
                        chk("w4_result", 33'({u4.cout, u4.sum}), e.res);
                        chk("w4_done_cycle", 33'(cyc), 33'(e.done_at));
                        chk("w4_busy_len", 33'(blen), 33'(4));
                    end
                    blen = 0;
                end
            end
        end
    end

    // 8-bit stimulus: reset state, directed cases, held start, ignored
    // start, mid-run reset, then random traffic.
    initial begin
        rst8 = 1'b1; u8.start = 1'b0; u8.a = 8'h00; u8.b = 8'h00; u8.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("w8_reset_sum", 33'(u8.sum), 33'(0));
        chk("w8_reset_cout", 33'(u8.cout), 33'(0));
        chk("w8_reset_busy", 33'(u8.busy), 33'(0));
        chk("w8_reset_done", 33'(u8.done), 33'(0));
        chk("w8_reset_fa", 33'({u8.fa_x, u8.fa_y, u8.fa_cin}), 33'(0));
        armed = 1'b1;
        rst8 = 1'b0;
        @(negedge clk);
        op8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        u8.start = 1'b0;
        repeat (2) @(negedge clk);
        op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
        op8(8'hC3, 8'h7E, 1'b1, 1'b0, 1'b1);
        // Abort an operation with reset in its 4th RUN cycle.
        u8.a = 8'hAA; u8.b = 8'h55; u8.cin = 1'b1; u8.start = 1'b1;
        @(negedge clk);
        u8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("w8_abort_busy", 33'(u8.busy), 33'(0));
        chk("w8_abort_done", 33'(u8.done), 33'(0));
        chk("w8_abort_sum", 33'(u8.sum), 33'(0));
        chk("w8_abort_cout", 33'(u8.cout), 33'(0));
        repeat (12) @(negedge clk);
        op8(8'h81, 8'h7F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        end
        repeat (4) @(negedge clk);
        fin8 = 1'b1;
    end

    // 4-bit exhaustive sweep, issued back to back from DONE.
    initial begin
        rst4 = 1'b1; u4.start = 1'b0; u4.a = 4'h0; u4.b = 4'h0; u4.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("w4_reset_sum", 33'({u4.cout, u4.sum}), 33'(0));
        rst4 = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c));
        repeat (4) @(negedge clk);
        fin4 = 1'b1;
    end

    // Completion and summary.
    initial begin
        wait (fin8 && fin4);
        chk("w8_pending_results", 33'(q8.size()), 33'(0));
        chk("w4_pending_results", 33'(q4.size()), 33'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, fin8=%0d fin4=%0d", fin8, fin4);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add the operands presented on a, b, cin.
REQ-005 a  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 cin  input  1  initial carry, sampled only on an accepted start.
REQ-008 fa_x  output  1  bit of A driven to the external one-bit full adder cell.
REQ-009 fa_y  output  1  bit of B driven to the full adder cell.
REQ-010 fa_cin  output  1  running carry driven to the full adder cell.
REQ-011 fa_s  input  1  sum returned by the full adder cell; combinational from fa_x, fa_y, fa_cin.
REQ-012 fa_cout  input  1  carry returned by the full adder cell.
REQ-013 sum  output  WIDTH  result; valid from done onward.
REQ-014 cout  output  1  final carry; valid from done onward.
REQ-015 busy  output  1  high while bits are being processed.
REQ-016 done  output  1  one-cycle pulse; result complete.

Function
REQ-017 The block SHALL be a three-state FSM: IDLE, RUN and DONE.
REQ-018 IDLE: start=1 SHALL transfer to RUN at the next edge.
  - Loads a_sh=a, b_sh=b, carry=cin.
  - Clears bit counter and sum shift register.
REQ-019 RUN, per cycle:
  - fa_x=a_sh[0], fa_y=b_sh[0], fa_cin=carry.
  - At the edge: a_sh, b_sh shift right one; sum_sh shifts right with fa_s entering the MSB; carry<=fa_cout; counter increments.
REQ-020 RUN SHALL last exactly WIDTH cycles; on the edge that stores bit WIDTH-1, the FSM SHALL go to DONE.
REQ-021 DONE SHALL last one cycle with done=1; the FSM then returns to IDLE.
  - Exception: start=1 in DONE SHALL reload per REQ-018 and go directly to RUN.
REQ-022 busy SHALL be 1 only in RUN.
REQ-023 In IDLE and DONE, fa_x, fa_y and fa_cin SHALL be 0.
REQ-024 Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH.
  - Total: WIDTH+1 cycles from start sample to done.
REQ-025 sum SHALL equal (a+b+cin) mod 2^WIDTH; cout SHALL equal bit WIDTH of a+b+cin.
  - Both held stable from done until the next accepted start reloads.
REQ-026 start during RUN SHALL be ignored; a, b and cin SHALL NOT be resampled.
REQ-027 Operand changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-028 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-029 rst=1 at an edge SHALL force the following, overriding start:
  - FSM = IDLE.
  - sum=0, cout=0, carry=0, counter=0, busy=0, done=0, fa_*=0.
REQ-030 rst asserted mid-RUN SHALL abort the operation.
  - No done pulse is produced.
  - Partial results SHALL NOT appear on sum.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> done 9 cycles later, sum=0x8D, cout=0, busy high for 8 cycles.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 start held high continuously with a=0x10, b=0x20 -> done every 9th cycle, sum=0x30 each time, no IDLE cycle between operations.
REQ-034 start pulsed mid-RUN with different operands -> ignored; original result delivered on schedule.
REQ-035 rst asserted in 4th RUN cycle -> next cycle busy=0, sum=0, cout=0; no done; fresh start then yields a correct result.
REQ-036 Exhaustive WIDTH=4 sweep of all a, b, cin against the reference model; fa_x, fa_y, fa_cin are 0 outside RUN.
